// File: rtl/iir_pkg.sv
// Shared types for the IIR input streaming stage.
// Output-register state, coefficient types and small helpers.
package iir_pkg;

  localparam int unsigned DEF_COEFF_WIDTH = 18;
  localparam int unsigned DEF_INPUT_TAPS  = 3;
  localparam int unsigned DEF_OUTPUT_TAPS = 2;

  typedef enum logic {
    OUT_EMPTY  = 1'b0,
    OUT_LOADED = 1'b1
  } out_state_t;

  typedef logic signed [DEF_COEFF_WIDTH-1:0] coeff_t;
  typedef coeff_t [DEF_INPUT_TAPS-1:0]  coeff_x_t;
  typedef coeff_t [DEF_OUTPUT_TAPS-1:0] coeff_y_t;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iir_sample_fifo.sv
// Sample buffer behind the output register.
// Pointers carry one extra bit so full and empty differ.
module iir_sample_fifo #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        push_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        pop_i,
  output logic [DATA_WIDTH-1:0]       head_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        empty_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_q;
  logic [AW:0]           rd_q;

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/iir_stream_tx.sv
// Feeds samples to an IIR core through a FIFO plus output register,
// with double-buffered coefficients swapped only between transfers.
module iir_stream_tx
  import iir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int unsigned INPUT_TAPS  = DEF_INPUT_TAPS,
  parameter int unsigned OUTPUT_TAPS = DEF_OUTPUT_TAPS,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic s_valid_i,
  output logic s_ready_o,
  output logic [DATA_WIDTH-1:0] m_x_o,
  output logic m_valid_o,
  input  logic m_ready_and_i,
  input  logic cfg_we_i,
  input  logic cfg_sel_i,
  input  logic [$clog2(max2(INPUT_TAPS,
    OUTPUT_TAPS))-1:0] cfg_idx_i,
  input  logic [COEFF_WIDTH-1:0] cfg_data_i,
  input  logic cfg_commit_i,
  output logic [INPUT_TAPS-1:0]
    [COEFF_WIDTH-1:0] coeff_x_o,
  output logic [OUTPUT_TAPS-1:0]
    [COEFF_WIDTH-1:0] coeff_y_o,
  output logic commit_pending_o,
  input  logic flush_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int unsigned IDX_W =
    $clog2(max2(INPUT_TAPS, OUTPUT_TAPS));
  localparam int unsigned LVL_W =
    $clog2(FIFO_DEPTH) + 1;

  out_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] head;
  logic [LVL_W-1:0]      fifo_cnt;
  logic                  fifo_empty;
  logic                  push, pop;
  logic                  up_fire, dn_fire;
  logic                  take, swap;

  logic [INPUT_TAPS-1:0][COEFF_WIDTH-1:0]  stg_x, act_x;
  logic [OUTPUT_TAPS-1:0][COEFF_WIDTH-1:0] stg_y, act_y;
  logic                                    pend_q;

  assign m_valid_o = (state_q == OUT_LOADED);
  assign m_x_o     = x_q;
  assign level_o   = fifo_cnt + LVL_W'(m_valid_o);
  assign s_ready_o = (level_o <= LVL_W'(FIFO_DEPTH));
  assign up_fire   = s_valid_i & s_ready_o;
  assign dn_fire   = m_valid_o & m_ready_and_i;
  assign take      = !m_valid_o | dn_fire;

  iir_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .push_i  (push),
    .data_i  (s_data_i),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (take) begin
      if (!fifo_empty) begin
        state_d = OUT_LOADED;
        x_d     = head;
        pop     = 1'b1;
        push    = up_fire;
      end else if (up_fire) begin
        state_d = OUT_LOADED;
        x_d     = s_data_i;
      end else begin
        state_d = OUT_EMPTY;
      end
    end else begin
      push = up_fire;
    end
    if (flush_i) begin
      state_d = OUT_EMPTY;
      push    = 1'b0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= OUT_EMPTY;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
    end
  end

  // Swap waits for a cycle with no sample leaving the stage
  assign swap = pend_q & ~dn_fire;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stg_x  <= '0;
      stg_y  <= '0;
      act_x  <= '0;
      act_y  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (swap) begin
        act_x <= stg_x;
        act_y <= stg_y;
      end
      pend_q <= swap ? 1'b0 : (pend_q | cfg_commit_i);
      if (cfg_we_i && !cfg_sel_i) begin
        for (int i = 0; i < INPUT_TAPS; i++)
          if (cfg_idx_i == IDX_W'(i))
            stg_x[i] <= cfg_data_i;
      end
      if (cfg_we_i && cfg_sel_i) begin
        for (int i = 0; i < OUTPUT_TAPS; i++)
          if (cfg_idx_i == IDX_W'(i))
            stg_y[i] <= cfg_data_i;
      end
    end
  end

  assign coeff_x_o        = act_x;
  assign coeff_y_o        = act_y;
  assign commit_pending_o = pend_q;

endmodule

// File: tb/tb_iir_stream_tx.sv
// Bench for iir_stream_tx: queue-based reference model,
// directed scenarios plus randomized traffic and config.
module tb_iir_stream_tx;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] m_x;
  logic        m_valid;
  logic        m_ready;
  logic        cfg_we;
  logic        cfg_sel;
  logic [1:0]  cfg_idx;
  logic [17:0] cfg_data;
  logic        cfg_commit;
  logic [2:0][17:0] coeff_x;
  logic [1:0][17:0] coeff_y;
  logic        pending;
  logic        flush;
  logic [3:0]  level;

  int total = 0;
  int bad   = 0;

  logic [23:0] q[$];
  logic [17:0] sx[3];
  logic [17:0] sy[2];
  logic [17:0] ax[3];
  logic [17:0] ay[2];
  bit          mp;

  always #5 clk = ~clk;

  iir_stream_tx dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .s_data_i         (s_data),
    .s_valid_i        (s_valid),
    .s_ready_o        (s_ready),
    .m_x_o            (m_x),
    .m_valid_o        (m_valid),
    .m_ready_and_i    (m_ready),
    .cfg_we_i         (cfg_we),
    .cfg_sel_i        (cfg_sel),
    .cfg_idx_i        (cfg_idx),
    .cfg_data_i       (cfg_data),
    .cfg_commit_i     (cfg_commit),
    .coeff_x_o        (coeff_x),
    .coeff_y_o        (coeff_y),
    .commit_pending_o (pending),
    .flush_i          (flush),
    .level_o          (level)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      sx[i] = '0;
      ax[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      sy[i] = '0;
      ay[i] = '0;
    end
    mp = 1'b0;
  endtask

  task automatic model_update();
    int n;
    bit up, dn, sw;
    n  = q.size();
    up = s_valid && (n < 9);
    dn = (n > 0) && m_ready;
    sw = mp && !dn;
    if (flush) q.delete();
    else begin
      if (dn) void'(q.pop_front());
      if (up) q.push_back(s_data);
    end
    if (sw) begin
      for (int i = 0; i < 3; i++) ax[i] = sx[i];
      for (int i = 0; i < 2; i++) ay[i] = sy[i];
    end
    mp = sw ? 1'b0 : (mp | cfg_commit);
    if (cfg_we && !cfg_sel && cfg_idx < 2'd3)
      sx[cfg_idx] = cfg_data;
    if (cfg_we && cfg_sel && cfg_idx < 2'd2)
      sy[cfg_idx[0]] = cfg_data;
  endtask

  // Compare at negedge, then advance model to the next edge.
  task automatic step();
    @(negedge clk);
    if (!rst_i) model_reset();
    chk("s_ready", 32'(s_ready), 32'(q.size() < 9));
    chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("m_x", 32'(m_x), 32'(q[0]));
    chk("level", 32'(level), 32'(q.size()));
    for (int i = 0; i < 3; i++)
      chk("coeff_x", 32'(coeff_x[i]), 32'(ax[i]));
    for (int i = 0; i < 2; i++)
      chk("coeff_y", 32'(coeff_y[i]), 32'(ay[i]));
    chk("pending", 32'(pending), 32'(mp));
    if (rst_i) model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    s_valid    = 1'b0;
    s_data     = '0;
    cfg_we     = 1'b0;
    cfg_sel    = 1'b0;
    cfg_idx    = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    rst_i   = 1'b0;
    m_ready = 1'b0;
    idle_in();
    model_reset();
    repeat (3) step();
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_pend", 32'(pending), 0);
    rst_i = 1'b1;
    step();
    chk("ready_after_rst", 32'(s_ready), 1);

    // back-to-back stream with downstream always ready
    m_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1;
      s_data  = 24'(i);
      step();
      chk("pass_x", 32'(m_x), 32'(i));
      chk("pass_lvl", 32'(level), 1);
    end
    s_valid = 1'b0;
    step();
    chk("pass_drain", 32'(m_valid), 0);

    // fill to capacity with downstream stalled
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 24'(100 + i);
      step();
    end
    s_valid = 1'b0;
    chk("full_lvl", 32'(level), 9);
    chk("full_rdy", 32'(s_ready), 0);
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("full_order", 32'(m_x), 32'(100 + i));
      step();
    end
    chk("full_empty", 32'(m_valid), 0);

    // commit deferred by continuous transfers
    cfg_we   = 1'b1;
    cfg_sel  = 1'b0;
    cfg_idx  = 2'd0;
    cfg_data = 18'h04000;
    step();
    cfg_we  = 1'b0;
    s_valid = 1'b1;
    s_data  = 24'h000055;
    step();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("defer_pend", 32'(pending), 1);
      chk("defer_cx0", 32'(coeff_x[0]), 0);
      s_data = 24'(k + 7);
      step();
    end
    s_valid = 1'b0;
    step();
    chk("defer_pend2", 32'(pending), 1);
    step();
    chk("swap_cx0", 32'(coeff_x[0]), 32'h4000);
    chk("swap_pend", 32'(pending), 0);

    // flush drops buffer and same-cycle input
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 24'(200 + i);
      step();
    end
    chk("pre_flush_lvl", 32'(level), 5);
    flush  = 1'b1;
    s_data = 24'h000123;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("flush_lvl", 32'(level), 0);
    chk("flush_valid", 32'(m_valid), 0);
    s_valid = 1'b1;
    s_data  = 24'h7FFFFF;
    step();
    s_valid = 1'b0;
    chk("post_flush_x", 32'(m_x), 32'h7FFFFF);
    chk("post_flush_lvl", 32'(level), 1);
    m_ready = 1'b1;
    step();
    chk("post_flush_empty", 32'(m_valid), 0);

    // randomized traffic and configuration
    for (int c = 0; c < 3000; c++) begin
      s_valid    = ($urandom_range(0, 3) != 0);
      s_data     = 24'($urandom);
      m_ready    = ($urandom_range(0, 2) != 0) ^
                   (c[9] == 1'b1);
      cfg_we     = ($urandom_range(0, 5) == 0);
      cfg_sel    = 1'($urandom_range(0, 1));
      cfg_idx    = 2'($urandom_range(0, 3));
      cfg_data   = 18'($urandom);
      cfg_commit = ($urandom_range(0, 11) == 0);
      flush      = ($urandom_range(0, 79) == 0);
      step();
    end
    idle_in();
    m_ready = 1'b1;
    repeat (12) step();

    // reset with buffered data and a pending commit
    cfg_we   = 1'b1;
    cfg_idx  = 2'd1;
    cfg_data = 18'h01234;
    step();
    cfg_we  = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 24'(300 + i);
      step();
    end
    m_ready    = 1'b1;
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("prerst_pend", 32'(pending), 1);
    chk("prerst_lvl", 32'(level), 4);
    rst_i = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 0);
    chk("arst_x", 32'(m_x), 0);
    chk("arst_lvl", 32'(level), 0);
    chk("arst_pend", 32'(pending), 0);
    chk("arst_cx0", 32'(coeff_x[0]), 0);
    chk("arst_cx1", 32'(coeff_x[1]), 0);
    chk("arst_cy0", 32'(coeff_y[0]), 0);
    idle_in();
    step();
    step();
    rst_i = 1'b1;
    step();
    chk("rel_ready", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data  = 24'h000005;
    step();
    s_valid = 1'b0;
    chk("rel_x", 32'(m_x), 5);
    chk("rel_lvl", 32'(level), 1);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iir_stream_tx.md
IIR_STREAM_TX -- requirements
Module: iir_stream_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 24, sample width (two's complement).
REQ-002 SHALL have parameter COEFF_WIDTH, 18, coefficient width (signed).
REQ-003 SHALL have parameter INPUT_TAPS, 3, number of feed-forward coefficients.
REQ-004 SHALL have parameter OUTPUT_TAPS, 2, number of feedback coefficients.
REQ-005 SHALL have parameter FIFO_DEPTH, 8, sample buffer depth; power of two, at least 2.
REQ-006 SHALL have ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- s_data_i  in  DATA_WIDTH  upstream sample.
- s_valid_i  in  1  upstream sample valid.
- s_ready_o  out  1  buffer can accept.
- m_x_o  out  DATA_WIDTH  sample to filter.
- m_valid_o  out  1  m_x_o valid.
- m_ready_and_i  in  1  filter ready.
- cfg_we_i  in  1  staged coefficient write strobe.
- cfg_sel_i  in  1  0 = x bank, 1 = y bank.
- cfg_idx_i  in  clog2(max(INPUT_TAPS,OUTPUT_TAPS))  coefficient index.
- cfg_data_i  in  COEFF_WIDTH  coefficient value.
- cfg_commit_i  in  1  request staged-to-active swap.
- coeff_x_o  out  COEFF_WIDTH x INPUT_TAPS  active x coefficients.
- coeff_y_o  out  COEFF_WIDTH x OUTPUT_TAPS  active y coefficients.
- commit_pending_o  out  1  swap requested, not yet applied.
- flush_i  in  1  discard all buffered samples.
- level_o  out  clog2(FIFO_DEPTH)+1  samples held (FIFO plus output register).

Function
REQ-007 SHALL complete a transfer on a side only in a cycle where valid and ready are both high at the clock edge.
REQ-008 SHALL drive s_ready_o = (level_o < FIFO_DEPTH+1) from registered state only, with no combinational path from m_ready_and_i.
REQ-009 SHALL drive m_x_o/m_valid_o from an output register: state EMPTY (m_valid_o=0) or LOADED (m_valid_o=1).
REQ-010 EMPTY->LOADED when FIFO non-empty, or when FIFO empty and an upstream transfer occurs (bypass); latency from upstream transfer at edge N to m_valid_o high is one cycle (after edge N).
REQ-011 LOADED->LOADED (next word) on downstream transfer with FIFO non-empty; LOADED->EMPTY on downstream transfer with FIFO empty and no bypass; otherwise hold m_x_o stable.
REQ-012 SHALL preserve sample order; simultaneous upstream and downstream transfers leave level_o unchanged.
REQ-013 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; full and empty distinguished by an extra pointer bit.
REQ-014 cfg_we_i SHALL write cfg_data_i to staged bank entry cfg_idx_i; writes to indices >= tap count of the selected bank SHALL be ignored.
REQ-015 cfg_commit_i SHALL set commit_pending_o; the swap staged->active SHALL occur on the first edge with commit_pending_o high and no downstream transfer, then clear commit_pending_o.
REQ-016 Active coefficients SHALL never change in a cycle with a downstream transfer, so each sample pairs with one coherent coefficient set.
REQ-017 cfg_commit_i with commit already pending SHALL be absorbed (single swap); cfg_we_i in the same cycle as the swap SHALL write staged bank after the copy (new value not active).
REQ-018 flush_i SHALL, at the next edge, empty FIFO and output register (level_o=0, m_valid_o=0) and drop any same-cycle upstream transfer; coefficient state unaffected.

Reset
REQ-019 On rst_i low: m_valid_o=0, m_x_o=0, level_o=0, pointers=0, commit_pending_o=0, staged and active coefficients all 0; s_ready_o=1 from first edge after release.
REQ-020 Reset asserted mid-transfer SHALL discard all buffered samples with no partial output.

Structure
REQ-021 Output-stage state enum and coefficient array typedefs SHALL live in shared package iir_pkg.
REQ-022 FIFO storage and pointers SHALL be sub-module iir_sample_fifo (parameters DATA_WIDTH, FIFO_DEPTH).

Verification
REQ-023 Send 1,2,3 with m_ready_and_i=1 -> m_x_o 1,2,3 each one cycle after acceptance, level_o max 1.
REQ-024 m_ready_and_i=0, push 10 samples (DEPTH 8) -> 9 accepted, s_ready_o=0 at level_o=9; release ready -> all 9 out in order, no loss.
REQ-025 Write staged x[0]=0x4000, commit while m_valid_o=1 and m_ready_and_i=1 every cycle for 3 cycles -> swap deferred until first non-transfer cycle; coeff_x_o[0]=0x4000 afterwards.
REQ-026 Level 5, flush_i with simultaneous s_valid_i -> next cycle level_o=0, m_valid_o=0; next sample 0x7FFFFF emerges alone.
REQ-027 Assert rst_i low with level 4 and commit pending -> all outputs at reset values, coefficients 0.
